// File: rtl/ir_nec_pkg.sv
// Shared NEC IR protocol definitions: FSM states and unit counts, also used by the receive path.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StRepSpace,
        StBitMark,
        StBitSpace,
        StStopMark,
        StGap
    } nec_state_e;

    localparam int unsigned LEAD_MARK_U  = 16;
    localparam int unsigned LEAD_SPACE_U = 8;
    localparam int unsigned REP_SPACE_U  = 4;
    localparam int unsigned BIT_MARK_U   = 1;
    localparam int unsigned ZERO_SPACE_U = 1;
    localparam int unsigned ONE_SPACE_U  = 3;
    localparam int unsigned STOP_U       = 1;
    localparam int unsigned FRAME_BITS   = 32;

    function automatic logic is_mark(nec_state_e s);
        return (s == StLeadMark) || (s == StBitMark) || (s == StStopMark);
    endfunction

endpackage

// File: rtl/ir_nec_transmitter_if.sv
// Request/status bundle between a frame producer and the NEC transmitter.
interface ir_nec_transmitter_if;
    logic       start;
    logic       repeat_req;
    logic [7:0] addr;
    logic [7:0] cmd;
    logic       ready;
    logic       done;
    logic       ir_env;
    logic       ir_led;

    modport master (
        output start, repeat_req, addr, cmd,
        input  ready, done, ir_env, ir_led
    );

    modport slave (
        input  start, repeat_req, addr, cmd,
        output ready, done, ir_env, ir_led
    );
endinterface

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier that restarts high whenever enable rises and is 0 while enable is low.
module ir_carrier_gen #(
    parameter int unsigned CARRIER_HALF = 658
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic out
);

    localparam int unsigned CntW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CARRIER_HALF - 1);

    logic [CntW-1:0] r_cnt;
    logic            r_phase;

    // Phase idles high so the first clock of every mark is already a carrier high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (!enable) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_cnt == CntLast) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out = enable & r_phase;

endmodule

// File: rtl/ir_nec_transmitter.sv
// NEC IR frame / repeat-code transmitter with active-low envelope and modulated LED drive.
module ir_nec_transmitter
    import ir_nec_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES  = 28125,
    parameter int unsigned CARRIER_HALF = 658,
    parameter bit          CARRIER_EN   = 1'b1,
    parameter int unsigned GAP_UNITS    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    ir_nec_transmitter_if.slave   bus
);

    if (GAP_UNITS < 1 || GAP_UNITS > 127) begin : g_bad_gap
        $error("GAP_UNITS must be in 1..127");
    end
    if (UNIT_CYCLES < 1 || CARRIER_HALF < 1) begin : g_bad_timing
        $error("UNIT_CYCLES and CARRIER_HALF must be at least 1");
    end

    localparam int unsigned PreW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(UNIT_CYCLES - 1);

    nec_state_e      r_state, w_state_d;
    logic [PreW-1:0] r_pre, w_pre_d;
    logic [6:0]      r_units, w_units_d;
    logic [31:0]     r_shift, w_shift_d;
    logic [5:0]      r_bits, w_bits_d;
    logic            r_rep, w_rep_d;
    logic            r_ready, r_done, r_env;

    logic       w_tick, w_last, w_mark, w_carrier;
    logic [6:0] w_target;

    assign w_tick = (r_state != StIdle) && (r_pre == PreLast);
    assign w_last = w_tick && (r_units == w_target - 7'd1);

    always_comb begin
        w_target = 7'd1;
        unique case (r_state)
            StLeadMark:  w_target = 7'(LEAD_MARK_U);
            StLeadSpace: w_target = 7'(LEAD_SPACE_U);
            StRepSpace:  w_target = 7'(REP_SPACE_U);
            StBitMark:   w_target = 7'(BIT_MARK_U);
            StBitSpace:  w_target = r_shift[0] ? 7'(ONE_SPACE_U) : 7'(ZERO_SPACE_U);
            StStopMark:  w_target = 7'(STOP_U);
            StGap:       w_target = 7'(GAP_UNITS);
            default:     w_target = 7'd1;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_pre_d   = r_pre;
        w_units_d = r_units;
        w_shift_d = r_shift;
        w_bits_d  = r_bits;
        w_rep_d   = r_rep;
        if (r_state == StIdle) begin
            w_pre_d   = '0;
            w_units_d = '0;
            if (bus.start) begin
                w_state_d = StLeadMark;
                w_shift_d = {~bus.cmd, bus.cmd, ~bus.addr, bus.addr};
                w_bits_d  = '0;
                w_rep_d   = 1'b0;
            end else if (bus.repeat_req) begin
                w_state_d = StLeadMark;
                w_bits_d  = '0;
                w_rep_d   = 1'b1;
            end
        end else begin
            w_pre_d = w_tick ? '0 : r_pre + 1'b1;
            if (w_last) begin
                w_units_d = '0;
                unique case (r_state)
                    StLeadMark:  w_state_d = r_rep ? StRepSpace : StLeadSpace;
                    StLeadSpace: w_state_d = StBitMark;
                    StRepSpace:  w_state_d = StStopMark;
                    StBitMark:   w_state_d = StBitSpace;
                    StBitSpace: begin
                        w_shift_d = r_shift >> 1;
                        w_bits_d  = r_bits + 6'd1;
                        w_state_d = (r_bits == 6'(FRAME_BITS - 1)) ? StStopMark : StBitMark;
                    end
                    StStopMark:  w_state_d = StGap;
                    default:     w_state_d = StIdle;
                endcase
            end else if (w_tick) begin
                w_units_d = r_units + 7'd1;
            end
        end
    end

    // Outputs are registered from next-state values so they align with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_pre   <= '0;
            r_units <= '0;
            r_shift <= '0;
            r_bits  <= '0;
            r_rep   <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_env   <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_pre   <= w_pre_d;
            r_units <= w_units_d;
            r_shift <= w_shift_d;
            r_bits  <= w_bits_d;
            r_rep   <= w_rep_d;
            r_ready <= (w_state_d == StIdle);
            r_done  <= (w_state_d == StStopMark) && (w_pre_d == PreLast);
            r_env   <= ~is_mark(w_state_d);
        end
    end

    assign w_mark = ~r_env;

    ir_carrier_gen #(
        .CARRIER_HALF (CARRIER_HALF)
    ) u_carrier (
        .clk    (clk),
        .reset  (reset),
        .enable (w_mark),
        .out    (w_carrier)
    );

    assign bus.ready  = r_ready;
    assign bus.done   = r_done;
    assign bus.ir_env = r_env;
    assign bus.ir_led = CARRIER_EN ? w_carrier : w_mark;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Directed bench for ir_nec_transmitter using shortened unit/carrier timing.
module tb_ir_nec_transmitter;

    localparam int unsigned U = 8;
    localparam int unsigned H = 3;
    localparam int unsigned G = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ir_nec_transmitter_if bus ();

    ir_nec_transmitter #(
        .UNIT_CYCLES  (U),
        .CARRIER_HALF (H),
        .CARRIER_EN   (1'b1),
        .GAP_UNITS    (G)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int run_len[$];
    bit run_lvl[$];
    int done_cnt, done_at, ready_at, led_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input bit s, input bit r, input logic [7:0] a, input logic [7:0] c);
        @(negedge clk);
        bus.start = s;
        bus.repeat_req = r;
        bus.addr = a;
        bus.cmd = c;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.repeat_req = 1'b0;
    endtask

    // Records envelope run lengths, done pulses and carrier errors until ready returns.
    task automatic capture(input int poke_at);
        int k;
        int len;
        bit lvl;
        bit exp_led;
        k = 0;
        len = 0;
        lvl = 1'b0;
        run_len.delete();
        run_lvl.delete();
        done_cnt = 0;
        done_at = -1;
        ready_at = -1;
        led_bad = 0;
        while (k < 4000) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.ready) begin
                ready_at = k;
                break;
            end
            if (bus.done) begin
                done_cnt++;
                done_at = k;
            end
            if (bus.ir_env == lvl) len++;
            else begin
                run_len.push_back(len);
                run_lvl.push_back(lvl);
                lvl = bus.ir_env;
                len = 1;
            end
            exp_led = (lvl == 1'b0) ? ((((len - 1) / H) % 2) == 0) : 1'b0;
            if (bus.ir_led !== exp_led) led_bad++;
            if (k == poke_at) begin
                bus.start = 1'b1;
                bus.addr = 8'hFF;
                bus.cmd = 8'h12;
            end
            k++;
        end
        run_len.push_back(len);
        run_lvl.push_back(lvl);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] a, input logic [7:0] c);
        logic [31:0] word;
        int bad;
        word = '0;
        bad = 0;
        check({tag, "_runs"}, run_len.size(), 68);
        if (run_len.size() == 68) begin
            check({tag, "_lead_lvl"}, {31'd0, run_lvl[0]}, 0);
            check({tag, "_lead_mark"}, run_len[0], 16 * U);
            check({tag, "_lead_space"}, run_len[1], 8 * U);
            for (int i = 0; i < 32; i++) begin
                if (run_len[2 + 2 * i] != U) bad++;
                if (run_len[3 + 2 * i] == 3 * U) word[i] = 1'b1;
                else if (run_len[3 + 2 * i] != U) bad++;
            end
            check({tag, "_word"}, word, {~c, c, ~a, a});
            check({tag, "_bad_bits"}, bad, 0);
            check({tag, "_stop"}, run_len[66], U);
            check({tag, "_gap"}, run_len[67], G * U);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_at"}, done_at, 121 * U - 1);
        check({tag, "_ready_at"}, ready_at, 121 * U + G * U);
        check({tag, "_led"}, led_bad, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.repeat_req = 1'b0;
        bus.addr = 8'h00;
        bus.cmd = 8'h00;

        #23;
        check("rst_ready", bus.ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_env", bus.ir_env, 1);
        check("rst_led", bus.ir_led, 0);
        @(negedge clk);
        reset = 1'b1;

        // Abort in the leader mark with an asynchronous reset.
        request(1'b1, 1'b0, 8'h00, 8'h00);
        check("acc_ready", bus.ready, 0);
        check("acc_env", bus.ir_env, 0);
        check("acc_led", bus.ir_led, 1);
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_env", bus.ir_env, 1);
        check("abort_led", bus.ir_led, 0);
        check("abort_ready", bus.ready, 1);
        @(negedge clk);
        reset = 1'b1;

        request(1'b1, 1'b0, 8'h00, 8'h00);
        capture(-1);
        check_frame("f0000", 8'h00, 8'h00);

        request(1'b1, 1'b0, 8'h5A, 8'h3C);
        capture(-1);
        check_frame("f5a3c", 8'h5A, 8'h3C);

        // Start pulsed inside the first bit space must be ignored.
        request(1'b1, 1'b0, 8'hA7, 8'h19);
        capture(8 * U * 3 + U + 2);
        check_frame("fpoke", 8'hA7, 8'h19);
        repeat (5) @(negedge clk);
        check("noqueue_ready", bus.ready, 1);
        check("noqueue_env", bus.ir_env, 1);

        request(1'b0, 1'b1, 8'h00, 8'h00);
        capture(-1);
        check("rep_runs", run_len.size(), 4);
        if (run_len.size() == 4) begin
            check("rep_lead", run_len[0], 16 * U);
            check("rep_space", run_len[1], 4 * U);
            check("rep_stop", run_len[2], U);
            check("rep_gap", run_len[3], G * U);
        end
        check("rep_done_cnt", done_cnt, 1);
        check("rep_done_at", done_at, 21 * U - 1);
        check("rep_ready_at", ready_at, 21 * U + G * U);
        check("rep_led", led_bad, 0);

        request(1'b1, 1'b1, 8'hC3, 8'h81);
        capture(-1);
        check_frame("fboth", 8'hC3, 8'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
